iq_mixer_decim: RTL

Quadrature down-converter and integrate-and-dump decimator that sits directly downstream of the NCO. Each valid input sample is multiplied by the NCO's cosine and negated sine to form I/Q products. Products are summed over DECIM samples, scaled, saturated, and presented as one I/Q pair on a valid/ready output. The output is the baseband feed for the later filtering and detection stages.

---
 rtl/iq_mixer_decim.sv | 116 +++++++++++
 1 files changed

// File: rtl/iq_mixer_decim.sv
// Quadrature mixer with integrate-and-dump decimation: sample x cos / -(sample x sine),
// summed over DECIM valid samples, scaled, saturated and held in a one-entry output register.
module iq_mixer_decim #(
    parameter int WAVE_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DECIM        = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int ACC_WIDTH    = SAMPLE_WIDTH + WAVE_WIDTH + $clog2(DECIM) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    input  logic signed [WAVE_WIDTH-1:0]   sine_in,
    input  logic signed [WAVE_WIDTH-1:0]   cos_in,
    output logic signed [OUT_WIDTH-1:0]    i_out,
    output logic signed [OUT_WIDTH-1:0]    q_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overrun,
    input  logic                           clear_overrun
);

    localparam int PROD_W = SAMPLE_WIDTH + WAVE_WIDTH + 1;
    localparam int CNT_W  = $clog2(DECIM);
    localparam int SHIFT  = WAVE_WIDTH - 1 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [ACC_WIDTH-1:0] scale(input logic signed [ACC_WIDTH-1:0] sum);
        return sum >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_WIDTH-1:0];
        else
            return v[OUT_WIDTH-1:0];
    endfunction

    logic signed [PROD_W-1:0]    i_prod_p1, q_prod_p1;
    logic                        vld_p1;
    logic signed [ACC_WIDTH-1:0] i_acc_p2, q_acc_p2;
    logic [CNT_W-1:0]            count_p2;
    logic signed [ACC_WIDTH-1:0] i_sum, q_sum;
    logic                        dump, drop;

    // Stage 1: product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            i_prod_p1 <= '0;
            q_prod_p1 <= '0;
        end else begin
            vld_p1 <= sample_valid;
            if (sample_valid) begin
                i_prod_p1 <= PROD_W'(sample_in) * PROD_W'(cos_in);
                q_prod_p1 <= -(PROD_W'(sample_in) * PROD_W'(sine_in));
            end
        end
    end

    assign i_sum = i_acc_p2 + ACC_WIDTH'(i_prod_p1);
    assign q_sum = q_acc_p2 + ACC_WIDTH'(q_prod_p1);
    assign dump  = vld_p1 && (count_p2 == CNT_LAST);
    // An occupied, unaccepted output register means the fresh result is lost.
    assign drop  = dump && out_valid && !out_ready;

    // Stage 2: integrate and dump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_acc_p2 <= '0;
            q_acc_p2 <= '0;
            count_p2 <= '0;
        end else if (vld_p1) begin
            if (dump) begin
                i_acc_p2 <= '0;
                q_acc_p2 <= '0;
                count_p2 <= '0;
            end else begin
                i_acc_p2 <= i_sum;
                q_acc_p2 <= q_sum;
                count_p2 <= count_p2 + CNT_W'(1);
            end
        end
    end

    // Stage 3: output register and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (dump && !drop) begin
                i_out     <= sat(scale(i_sum));
                q_out     <= sat(scale(q_sum));
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

endmodule
